// File: rtl/alu_status_reg.sv
// -----------------------------------------------------------------------------
// alu_status_reg
//   Registered output stage that sits right after the ALU and its flag logic.
//   A word is accepted through a valid/ready handshake. The stage stores the
//   ALU result and derives N and Z from it. It keeps the C and V flags only for
//   add and sub; for any other opcode they are stored as 0. The stored word is
//   held bit-stable until the consumer takes it. A sticky overflow flag records
//   any accepted overflow until software clears it.
//
// Optional feature (compile-time macro):
//   OVF_COUNT_EN  builds a saturating counter of accepted words with V=1.
//                 When the macro is undefined, ovf_count is tied to 0.
//
// Parameters:
//   size   data width of the ALU result
//   CNT_W  width of the overflow event counter
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    ALU result and flags are present this cycle
//   in_ready    stage can accept a word (!out_valid | out_ready)
//   in_result   ALU result
//   in_alusel   ALU opcode (4'b0000 add, 4'b0001 sub)
//   in_c        carry/borrow from the ALU
//   in_v        overflow from the overflow-flag block
//   out_valid   registered word is held for the consumer
//   out_ready   consumer takes the word this cycle
//   out_result  registered result
//   out_n       sign of the registered result
//   out_z       registered result is zero
//   out_c       carry, gated to add/sub
//   out_v       overflow, gated to add/sub
//   sticky_v    set by any accepted V=1, held until clr_sticky
//   clr_sticky  synchronous clear of sticky_v and ovf_count
//   ovf_count   saturating count of accepted V=1 words
// -----------------------------------------------------------------------------
module alu_status_reg #(
  parameter int size  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [size-1:0]  in_result,
  input  logic [3:0]       in_alusel,
  input  logic             in_c,
  input  logic             in_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [size-1:0]  out_result,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v,
  output logic             sticky_v,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic accept;
  logic is_arith;
  logic gated_c;
  logic gated_v;

  // The stage is ready whenever the held word is absent or leaves this cycle.
  // This lets words pass back-to-back with no bubble.
  assign in_ready  = (state == EMPTY) | out_ready;
  assign out_valid = (state == FULL);
  assign accept    = in_valid & in_ready;

  // C and V only have meaning for add and sub. Other opcodes report 0.
  assign is_arith = (in_alusel == 4'b0000) | (in_alusel == 4'b0001);
  assign gated_c  = is_arith & in_c;
  assign gated_v  = is_arith & in_v;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (out_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Captured word. It updates only on accept, so it stays bit-stable while the
  // consumer stalls. in_* is ignored when in_ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_n      <= 1'b0;
      out_z      <= 1'b0;
      out_c      <= 1'b0;
      out_v      <= 1'b0;
    end else if (accept) begin
      out_result <= in_result;
      out_n      <= in_result[size-1];
      out_z      <= (in_result == {size{1'b0}});
      out_c      <= gated_c;
      out_v      <= gated_v;
    end
  end

  // A new overflow takes priority over a clear in the same cycle, so that
  // event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    sticky_v <= 1'b0;
    else if (accept && gated_v) sticky_v <= 1'b1;
    else if (clr_sticky)        sticky_v <= 1'b0;
  end

`ifdef OVF_COUNT_EN
  logic [CNT_W-1:0] ovf_cnt_q;

  // A clear together with an increment gives a count of 1. That is the
  // overflow that arrived in the clearing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else if (clr_sticky) begin
      ovf_cnt_q <= (accept && gated_v) ? CNT_W'(1) : '0;
    end else if (accept && gated_v && (ovf_cnt_q != {CNT_W{1'b1}})) begin
      ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
    end
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = '0;
`endif

endmodule
